vec_mem_unit: RTL and testbench
===============================

Name: vec_mem_unit

Overview:
- Multi-cycle vector load/store engine in the memory stage, directly downstream of the vector ALU.
- Store: takes the 256-bit vector ALU result and serialises it to 16-bit data memory, one lane per cycle.
- Load: gathers 16 consecutive 16-bit memory elements into a 256-bit word for vector register writeback.
- Holds the pipeline via busy while active.

Parameters:
- LANES, 16, number of 16-bit elements per vector
- LANE_W, 16, element width in bits
- ADDR_W, 32, memory element-address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only in IDLE
- op_store  in  1  1 = vector store, 0 = vector load
- scalar_mode  in  1  operate on lane 0 only
- base_addr  in  ADDR_W  element address of lane 0
- wdata  in  LANES*LANE_W  store data (vector ALU result); lane i = bits [16i+15:16i]
- busy  out  1  high whenever state != IDLE; pipeline stall
- done  out  1  one-cycle completion pulse
- rdata  out  LANES*LANE_W  load result
- mem_addr  out  ADDR_W  memory element address
- mem_wdata  out  LANE_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  LANE_W  read data, valid exactly one cycle after mem_re

Behaviour:
- Reset, asynchronous: state = IDLE. busy, done, mem_we, mem_re = 0. mem_addr, mem_wdata = 0. rdata = 0. Lane counter = 0.
- Reset mid-operation aborts immediately. No further memory strobes. Partial load data is discarded.
- Acceptance:
  - At a clock edge with state == IDLE and start == 1, latch op_store, scalar_mode, base_addr and wdata.
  - Set count = 1 if scalar_mode, else LANES.
  - start is ignored while busy; it is not queued.
- States: IDLE, STORE, LOAD, DRAIN, DONE.
- STORE:
  - One cycle per lane i = 0..count-1.
  - mem_we = 1, mem_addr = base + i, mem_wdata = latched lane i.
  - After the last lane, go to DONE.
- LOAD:
  - One cycle per lane i = 0..count-1.
  - mem_re = 1, mem_addr = base + i.
  - Each cycle also captures mem_rdata into rdata lane i-1 (for i >= 1).
  - After the last request, go to DRAIN.
- DRAIN: mem_re = 0; capture the last lane (index count-1); go to DONE.
- DONE: done = 1 for one cycle, busy still 1; go to IDLE.
- Latency, start accepted at edge 0:
  - Full store: writes in cycles 1..16, done in cycle 17.
  - Full load: reads in cycles 1..16, done in cycle 18.
  - Scalar store: done in cycle 2.
  - Scalar load: done in cycle 3.
- rdata:
  - Cleared to 0 on load acceptance, so unwritten lanes are zero in scalar mode.
  - Holds its value until the next load is accepted.
  - Stores never modify rdata.
- Address arithmetic: base + i computed modulo 2^ADDR_W; wraps without error (base = 0xFFFFFFFF gives lane 1 at address 0).
- mem_addr and mem_wdata return to 0 in every state other than STORE/LOAD.
- mem_we and mem_re are never high simultaneously.
- start asserted in the DONE cycle is ignored. A start held high is accepted on the first IDLE edge, so back-to-back ops have a 1-cycle IDLE gap.

Decomposition:
- Package vec_mem_pkg:
  - constants LANES, LANE_W, VEC_W = LANES*LANE_W
  - state enum vmem_state_t {IDLE, STORE, LOAD, DRAIN, DONE}
  - typedef lane_t = logic [LANE_W-1:0]
- Sub-module vec_lane_sel: combinational 16:1 lane multiplexer selecting a 16-bit lane from a 256-bit vector by a 4-bit index. Used for mem_wdata generation.

Test Plan:
- Full store: base = 0x100, wdata lanes = 0x0000..0x000F, start one cycle.
  - mem_we high cycles 1..16, addresses 0x100..0x10F, data 0x0000..0x000F.
  - done pulse cycle 17; busy high cycles 1..17.
- Full load: memory model returns (addr ^ 0xA5A5) one cycle after mem_re, base = 0x200.
  - rdata lane i = (0x200+i) ^ 0xA5A5 at done, cycle 18.
  - mem_re high exactly 16 cycles.
- Scalar load after a full load: base = 0x40, memory returns 0x1234.
  - rdata = {240'b0, 16'h1234}; done in cycle 3.
  - Single mem_re.
- Scalar store with base = 0xFFFF_FFFF, lane0 = 0xBEEF.
  - One write to 0xFFFF_FFFF, data 0xBEEF; done cycle 2.
- Address wrap, full store with base = 0xFFFF_FFFF: lane 1 goes to address 0x0, lane 15 to 0xE.
- Robustness:
  - rst_n pulsed low during LOAD cycle 8: all outputs 0 immediately, state IDLE.
  - start pulsed during busy: ignored, no extra memory strobes.
  - start held high: second op begins after one IDLE cycle.

Source files
------------

// File: rtl/vec_mem_pkg.sv
// Shared constants and types for the vector load/store engine.
// Lane geometry, address width, FSM state encoding and lane/index types.
package vec_mem_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        DRAIN,
        DONE
    } vmem_state_t;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/vec_lane_sel.sv
// Combinational 16:1 lane multiplexer.
// Ports: vec_i (256-bit vector), sel_i (lane index), lane_o (selected lane).
module vec_lane_sel
    import vec_mem_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    input  idx_t             sel_i,
    output lane_t            lane_o
);

    assign lane_o = vec_i[sel_i*LANE_W +: LANE_W];

endmodule

// File: rtl/vec_mem_unit.sv
// Multi-cycle vector load/store engine: serialises a 256-bit vector to
// 16-bit memory (store) or gathers 16 elements into rdata (load).
// Ports: clk/rst_n; start, op_store, scalar_mode, base_addr, wdata request;
// busy/done status; rdata load result; mem_* single-lane memory port.
module vec_mem_unit
    import vec_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_store,
    input  logic              scalar_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [VEC_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output lane_t             mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  lane_t             mem_rdata
);

    vmem_state_t       state_q, state_d;
    idx_t              idx_q, idx_d;
    idx_t              last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [VEC_W-1:0]  wdata_q, wdata_d;
    logic [VEC_W-1:0]  rdata_q, rdata_d;

    lane_t             sel_lane;
    logic              cap_en;
    idx_t              cap_idx;
    logic              active;

    vec_lane_sel u_sel (
        .vec_i  (wdata_q),
        .sel_i  (idx_q),
        .lane_o (sel_lane)
    );

    // Read data lags the request by one cycle, so LOAD writes lane
    // idx-1 and DRAIN picks up the final lane.
    assign cap_en  = ((state_q == LOAD) && (idx_q != '0)) ||
                     (state_q == DRAIN);
    assign cap_idx = (state_q == DRAIN) ? last_q : idx_q - 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (cap_en) begin
            rdata_d[cap_idx*LANE_W +: LANE_W] = mem_rdata;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = op_store ? STORE : LOAD;
                    idx_d   = '0;
                    last_d  = scalar_mode ? '0 : idx_t'(LANES - 1);
                    base_d  = base_addr;
                    wdata_d = wdata;
                    if (!op_store) begin
                        rdata_d = '0;
                    end
                end
            end
            STORE, LOAD: begin
                if (idx_q == last_q) begin
                    state_d = (state_q == STORE) ? DONE : DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign active    = (state_q == STORE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_we    = (state_q == STORE);
    assign mem_re    = (state_q == LOAD);
    assign mem_addr  = active ? base_q + ADDR_W'(idx_q) : '0;
    assign mem_wdata = mem_we ? sel_lane : '0;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench for vec_mem_unit: vector table plus corner sequences.
// Memory model answers one cycle after mem_re.
module tb_vec_mem_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_store = 1'b0;
    logic         scalar_mode = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [255:0] wdata = '0;
    logic         busy, done, mem_we, mem_re;
    logic [255:0] rdata;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata = '0;
    logic         mem_mode = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         st;
        logic         sc;
        logic [31:0]  base;
        logic [255:0] wd;
        logic         mm;
        int           dcyc;
        int           nstb;
        logic [255:0] rd;
    } vec_t;

    vec_t tv[5];

    vec_mem_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_store    (op_store),
        .scalar_mode (scalar_mode),
        .base_addr   (base_addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem_mode ? 16'h1234 : (mem_addr[15:0] ^ 16'hA5A5);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [255:0] act,
                        input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_we"}, 32'(mem_we), 0);
        chk({nm, "_re"}, 32'(mem_re), 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_wdata"}, 32'(mem_wdata), 0);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cyc, nw, nr, dc;
        logic [31:0] ea;
        string tag;
        tag = $sformatf("v%0d", idx);
        mem_mode = v.mm;
        @(negedge clk);
        start = 1'b1;
        op_store = v.st;
        scalar_mode = v.sc;
        base_addr = v.base;
        wdata = v.wd;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nw = 0; nr = 0; dc = 0;
        while (dc == 0 && cyc <= 40) begin
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_excl"}, 32'(mem_we & mem_re), 0);
            if (mem_we) begin
                ea = v.base + nw;
                chk({tag, "_st_addr"}, mem_addr, ea);
                chk({tag, "_st_data"}, 32'(mem_wdata),
                    32'(v.wd[(nw % 16)*16 +: 16]));
                nw++;
            end
            if (mem_re) begin
                ea = v.base + nr;
                chk({tag, "_ld_addr"}, mem_addr, ea);
                nr++;
            end
            if (!mem_we && !mem_re) begin
                chk({tag, "_addr0"}, mem_addr, 0);
                chk({tag, "_wdata0"}, 32'(mem_wdata), 0);
            end
            if (done) begin
                dc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_cyc"}, dc, v.dcyc);
        chk({tag, "_we_cnt"}, nw, v.st ? v.nstb : 0);
        chk({tag, "_re_cnt"}, nr, v.st ? 0 : v.nstb);
        chkv({tag, "_rdata"}, rdata, v.rd);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_done"}, 32'(done), 0);
    endtask

    initial begin
        logic [255:0] w;
        logic [255:0] r;
        logic [15:0]  a;
        int nw, nr, nd;

        // vector table
        w = '0;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i);
        tv[0] = '{1'b1, 1'b0, 32'h100, w, 1'b0, 17, 16, 256'h0};
        r = '0;
        for (int i = 0; i < 16; i++) begin
            a = 16'h0200 + 16'(i);
            r[i*16 +: 16] = a ^ 16'hA5A5;
        end
        tv[1] = '{1'b0, 1'b0, 32'h200, '0, 1'b0, 18, 16, r};
        tv[2] = '{1'b0, 1'b1, 32'h40, '0, 1'b1, 3, 1,
                  {240'b0, 16'h1234}};
        w = {16{16'h1111}};
        w[15:0] = 16'hBEEF;
        tv[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, w, 1'b0, 2, 1,
                  {240'b0, 16'h1234}};
        w = '0;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'hC000 + 16'(i);
        tv[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, w, 1'b0, 17, 16,
                  {240'b0, 16'h1234}};

        // reset state
        repeat (3) @(negedge clk);
        chk_quiet("rst");
        chkv("rst_rdata", rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");

        for (int i = 0; i < 5; i++) run_op(tv[i], i);

        // reset pulsed during LOAD cycle 8
        mem_mode = 1'b0;
        @(negedge clk);
        start = 1'b1; op_store = 1'b0; scalar_mode = 1'b0;
        base_addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_re_pre", 32'(mem_re), 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        chkv("mid_rst_rdata", rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_quiet("after_rst");
        end

        // start pulsed while busy is ignored
        w = '0;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'hAB00 + 16'(i);
        @(negedge clk);
        start = 1'b1; op_store = 1'b1; scalar_mode = 1'b0;
        base_addr = 32'h500; wdata = w;
        nw = 0; nr = 0; nd = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                start = 1'b1; op_store = 1'b0; base_addr = 32'h900;
            end
            if (c == 17) begin
                start = 1'b1; op_store = 1'b0; base_addr = 32'h900;
            end
            nw += int'(mem_we);
            nr += int'(mem_re);
            nd += int'(done);
        end
        start = 1'b0;
        chk("ign_we_cnt", nw, 16);
        chk("ign_re_cnt", nr, 0);
        chk("ign_done_cnt", nd, 1);
        chk("ign_busy_end", 32'(busy), 0);

        // start held high: one IDLE cycle between ops
        @(negedge clk);
        start = 1'b1; op_store = 1'b1; scalar_mode = 1'b1;
        base_addr = 32'h600; wdata = {240'b0, 16'h0055};
        @(negedge clk);
        chk("hold_c1_we", 32'(mem_we), 1);
        @(negedge clk);
        chk("hold_c2_done", 32'(done), 1);
        chk("hold_c2_we", 32'(mem_we), 0);
        @(negedge clk);
        chk("hold_c3_busy", 32'(busy), 0);
        @(negedge clk);
        chk("hold_c4_we", 32'(mem_we), 1);
        chk("hold_c4_addr", mem_addr, 32'h600);
        chk("hold_c4_data", 32'(mem_wdata), 32'h55);
        start = 1'b0;
        @(negedge clk);
        chk("hold_c5_done", 32'(done), 1);
        @(negedge clk);
        chk("hold_c6_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
